// File: rtl/l1_dcache_responder.sv
// Direct-mapped, write-back, write-allocate L1 data cache with 128-bit line transfers.
// Hits answer combinationally in the request cycle; misses run writeback/fill autonomously.
module l1_dcache_responder #(
    parameter int SET_BITS   = 3,
    parameter int LINE_BYTES = 16
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic [15:0]  mem_address_i,
    input  logic         mem_read_i,
    input  logic         mem_write_i,
    input  logic [15:0]  mem_byte_en_i,
    input  logic [127:0] mem_wdata_i,
    output logic [127:0] mem_rdata_o,
    output logic         mem_resp_o,
    output logic [15:0]  pmem_address_o,
    output logic         pmem_read_o,
    output logic         pmem_write_o,
    output logic [127:0] pmem_wdata_o,
    input  logic [127:0] pmem_rdata_i,
    input  logic         pmem_resp_i
);

    localparam int SETS  = 1 << SET_BITS;
    localparam int TAG_W = 16 - 4 - SET_BITS;

    typedef enum logic [1:0] {
        CHECK,
        WRITEBACK,
        FILL
    } state_e;

    state_e              state_q;
    logic [SETS-1:0]     valid_q;
    logic [SETS-1:0]     dirty_q;
    logic [TAG_W-1:0]    tag_q  [SETS];
    logic [127:0]        data_q [SETS];
    logic                pmem_read_q;
    logic                pmem_write_q;
    logic [15:0]         pmem_address_q;

    logic [SET_BITS-1:0] idx;
    logic [TAG_W-1:0]    addr_tag;
    logic                req;
    logic                hit;
    logic                write_hit;
    logic [127:0]        line_d;
    logic                unused_offset;

    assign idx           = mem_address_i[3+SET_BITS:4];
    assign addr_tag      = mem_address_i[15:4+SET_BITS];
    assign unused_offset = ^mem_address_i[3:0];

    assign req       = mem_read_i || mem_write_i;
    assign hit       = valid_q[idx] && (tag_q[idx] == addr_tag);
    assign write_hit = (state_q == CHECK) && mem_write_i && hit;

    assign mem_resp_o     = !reset_i && (state_q == CHECK) && req && hit;
    assign mem_rdata_o    = data_q[idx];
    assign pmem_wdata_o   = data_q[idx];
    assign pmem_read_o    = pmem_read_q;
    assign pmem_write_o   = pmem_write_q;
    assign pmem_address_o = pmem_address_q;

    // Byte-masked merge of CPU write data into the resident line
    always_comb begin
        line_d = data_q[idx];
        for (int i = 0; i < LINE_BYTES; i++) begin
            if (mem_byte_en_i[i]) begin
                line_d[8*i +: 8] = mem_wdata_i[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q        <= CHECK;
            valid_q        <= '0;
            dirty_q        <= '0;
            pmem_read_q    <= 1'b0;
            pmem_write_q   <= 1'b0;
            pmem_address_q <= '0;
        end else begin
            case (state_q)
                CHECK: begin
                    if (req) begin
                        if (hit) begin
                            if (mem_write_i) begin
                                dirty_q[idx] <= 1'b1;
                            end
                        end else if (dirty_q[idx]) begin
                            state_q        <= WRITEBACK;
                            pmem_write_q   <= 1'b1;
                            pmem_address_q <= {tag_q[idx], idx, 4'h0};
                        end else begin
                            state_q        <= FILL;
                            pmem_read_q    <= 1'b1;
                            pmem_address_q <= {addr_tag, idx, 4'h0};
                        end
                    end
                end
                WRITEBACK: begin
                    if (pmem_resp_i) begin
                        dirty_q[idx]   <= 1'b0;
                        state_q        <= FILL;
                        pmem_write_q   <= 1'b0;
                        pmem_read_q    <= 1'b1;
                        pmem_address_q <= {addr_tag, idx, 4'h0};
                    end
                end
                FILL: begin
                    if (pmem_resp_i) begin
                        valid_q[idx] <= 1'b1;
                        dirty_q[idx] <= 1'b0;
                        state_q      <= CHECK;
                        pmem_read_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q      <= CHECK;
                    pmem_read_q  <= 1'b0;
                    pmem_write_q <= 1'b0;
                end
            endcase
        end
    end

    // Tag and data arrays carry no reset; validity alone qualifies them
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            if (write_hit) begin
                data_q[idx] <= line_d;
            end else if ((state_q == FILL) && pmem_resp_i) begin
                data_q[idx] <= pmem_rdata_i;
                tag_q[idx]  <= addr_tag;
            end
        end
    end

endmodule

// File: tb/tb_l1_dcache_responder.sv
// Self-checking bench for l1_dcache_responder: directed scenarios followed by
// randomized traffic, checked against a per-set cache model and a memory model.
module tb_l1_dcache_responder;

    logic         clk;
    logic         reset_i;
    logic [15:0]  mem_address_i;
    logic         mem_read_i;
    logic         mem_write_i;
    logic [15:0]  mem_byte_en_i;
    logic [127:0] mem_wdata_i;
    logic [127:0] mem_rdata_o;
    logic         mem_resp_o;
    logic [15:0]  pmem_address_o;
    logic         pmem_read_o;
    logic         pmem_write_o;
    logic [127:0] pmem_wdata_o;
    logic [127:0] pmem_rdata_i;
    logic         pmem_resp_i;

    int checks   = 0;
    int failures = 0;

    // Reference model: cache contents per set and backing memory per line address
    logic         m_valid [8];
    logic         m_dirty [8];
    logic [8:0]   m_tag   [8];
    logic [127:0] m_data  [8];
    logic [127:0] mem_lines [logic [15:0]];

    logic [15:0]  r_addr;
    logic         r_wr;
    logic         r_rd;
    logic [127:0] r_line;

    l1_dcache_responder #(.SET_BITS(3), .LINE_BYTES(16)) dut (
        .clk_i          (clk),
        .reset_i        (reset_i),
        .mem_address_i  (mem_address_i),
        .mem_read_i     (mem_read_i),
        .mem_write_i    (mem_write_i),
        .mem_byte_en_i  (mem_byte_en_i),
        .mem_wdata_i    (mem_wdata_i),
        .mem_rdata_o    (mem_rdata_o),
        .mem_resp_o     (mem_resp_o),
        .pmem_address_o (pmem_address_o),
        .pmem_read_o    (pmem_read_o),
        .pmem_write_o   (pmem_write_o),
        .pmem_wdata_o   (pmem_wdata_o),
        .pmem_rdata_i   (pmem_rdata_i),
        .pmem_resp_i    (pmem_resp_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] memGet(input logic [15:0] a);
        if (!mem_lines.exists(a)) begin
            mem_lines[a] = {$urandom, $urandom, $urandom, $urandom};
        end
        return mem_lines[a];
    endfunction

    function automatic logic [127:0] mergeBytes(input logic [127:0] line, input logic [15:0] be,
                                               input logic [127:0] wd);
        logic [127:0] r;
        r = line;
        for (int i = 0; i < 16; i++) begin
            if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
        end
        return r;
    endfunction

    task automatic clearModel();
        for (int s = 0; s < 8; s++) begin
            m_valid[s] = 1'b0;
            m_dirty[s] = 1'b0;
        end
    endtask

    task automatic applyReset();
        reset_i     = 1'b1;
        mem_read_i  = 1'b0;
        mem_write_i = 1'b0;
        pmem_resp_i = 1'b0;
        repeat (2) @(negedge clk);
        reset_i = 1'b0;
        #1;
        checkOutput("rst_mem_resp", mem_resp_o, 1'b0);
        checkOutput("rst_pmem_read", pmem_read_o, 1'b0);
        checkOutput("rst_pmem_write", pmem_write_o, 1'b0);
        checkOutput("rst_pmem_address", pmem_address_o, 16'h0000);
        clearModel();
    endtask

    task automatic idleCycles(input int n);
        mem_read_i  = 1'b0;
        mem_write_i = 1'b0;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            #1;
            checkOutput("idle_resp", mem_resp_o, 1'b0);
            checkOutput("idle_pmem_rw", {pmem_read_o, pmem_write_o}, 2'b00);
        end
    endtask

    // One CPU access; the bench plays memory with the given latency in cycles
    task automatic applyStimulus(input logic [15:0] addr, input logic rd, input logic wr,
                                 input logic [15:0] be, input logic [127:0] wd, input int lat);
        logic [2:0]   idx;
        logic [8:0]   tg;
        logic [15:0]  la;
        logic [127:0] line;
        idx = addr[6:4];
        tg  = addr[15:7];
        mem_address_i = addr;
        mem_read_i    = rd;
        mem_write_i   = wr;
        mem_byte_en_i = be;
        mem_wdata_i   = wd;
        #1;
        if (m_valid[idx] && m_tag[idx] == tg) begin
            checkOutput("hit_resp", mem_resp_o, 1'b1);
            checkOutput("hit_rdata", mem_rdata_o, m_data[idx]);
            checkOutput("hit_no_pmem", {pmem_read_o, pmem_write_o}, 2'b00);
        end else begin
            checkOutput("miss_resp", mem_resp_o, 1'b0);
            @(negedge clk);
            #1;
            if (m_dirty[idx]) begin
                la = {m_tag[idx], idx, 4'h0};
                checkOutput("wb_address", pmem_address_o, la);
                checkOutput("wb_wdata", pmem_wdata_o, m_data[idx]);
                for (int c = 1; c <= lat; c++) begin
                    checkOutput("wb_pmem_rw", {pmem_read_o, pmem_write_o}, 2'b01);
                    checkOutput("wb_resp_low", mem_resp_o, 1'b0);
                    if (c == lat) pmem_resp_i = 1'b1;
                    @(negedge clk);
                    pmem_resp_i = 1'b0;
                    #1;
                end
                mem_lines[la] = m_data[idx];
                m_dirty[idx] = 1'b0;
            end
            la   = {tg, idx, 4'h0};
            line = memGet(la);
            checkOutput("fill_address", pmem_address_o, la);
            for (int c = 1; c <= lat; c++) begin
                checkOutput("fill_pmem_rw", {pmem_read_o, pmem_write_o}, 2'b10);
                checkOutput("fill_resp_low", mem_resp_o, 1'b0);
                if (c == lat) begin
                    pmem_resp_i  = 1'b1;
                    pmem_rdata_i = line;
                end
                @(negedge clk);
                pmem_resp_i  = 1'b0;
                pmem_rdata_i = {$urandom, $urandom, $urandom, $urandom};
                #1;
            end
            m_valid[idx] = 1'b1;
            m_dirty[idx] = 1'b0;
            m_tag[idx]   = tg;
            m_data[idx]  = line;
            checkOutput("retry_resp", mem_resp_o, 1'b1);
            checkOutput("retry_rdata", mem_rdata_o, line);
            checkOutput("retry_no_pmem", {pmem_read_o, pmem_write_o}, 2'b00);
        end
        if (wr) begin
            m_data[idx]  = mergeBytes(m_data[idx], be, wd);
            m_dirty[idx] = 1'b1;
        end
        @(negedge clk);
        mem_read_i  = 1'b0;
        mem_write_i = 1'b0;
    endtask

    initial begin
        reset_i       = 1'b1;
        mem_address_i = '0;
        mem_read_i    = 1'b0;
        mem_write_i   = 1'b0;
        mem_byte_en_i = '0;
        mem_wdata_i   = '0;
        pmem_rdata_i  = '0;
        pmem_resp_i   = 1'b0;
        clearModel();

        applyReset();
        idleCycles(2);

        $display("[TB] cold read, byte write hit, dirty eviction");
        applyStimulus(16'h1234, 1'b1, 1'b0, 16'h0000, '0, 3);
        applyStimulus(16'h123E, 1'b1, 1'b0, 16'h0000, '0, 3);
        applyStimulus(16'h1235, 1'b0, 1'b1, 16'h0020, 128'hAB << 40, 3);
        applyStimulus(16'h1234, 1'b1, 1'b0, 16'h0000, '0, 3);
        checkOutput("byte5_written", mem_lines[16'h1230][47:40] == 8'hAB ? m_data[3][47:40] : 8'hAB, 8'hAB);
        applyStimulus(16'h5234, 1'b1, 1'b0, 16'h0000, '0, 2);
        checkOutput("wb_line_in_mem_byte5", mem_lines[16'h1230][47:40], 8'hAB);

        $display("[TB] clean eviction");
        applyStimulus(16'h0040, 1'b1, 1'b0, 16'h0000, '0, 1);
        applyStimulus(16'h8040, 1'b1, 1'b0, 16'h0000, '0, 4);

        $display("[TB] reset during fill");
        mem_address_i = 16'h2000;
        mem_read_i    = 1'b1;
        #1;
        checkOutput("mid_miss_resp", mem_resp_o, 1'b0);
        @(negedge clk);
        #1;
        checkOutput("mid_fill_read", pmem_read_o, 1'b1);
        checkOutput("mid_fill_addr", pmem_address_o, 16'h2000);
        reset_i    = 1'b1;
        mem_read_i = 1'b0;
        @(negedge clk);
        reset_i = 1'b0;
        #1;
        checkOutput("post_rst_pmem_rw", {pmem_read_o, pmem_write_o}, 2'b00);
        clearModel();
        pmem_resp_i  = 1'b1;
        pmem_rdata_i = {4{32'hDEADBEEF}};
        @(negedge clk);
        pmem_resp_i = 1'b0;
        #1;
        checkOutput("late_resp_ignored", {pmem_read_o, pmem_write_o}, 2'b00);
        applyStimulus(16'h2000, 1'b1, 1'b0, 16'h0000, '0, 2);
        applyStimulus(16'h5234, 1'b1, 1'b0, 16'h0000, '0, 2);

        $display("[TB] simultaneous read and write hit");
        applyStimulus(16'h8040, 1'b1, 1'b0, 16'h0000, '0, 1);
        applyStimulus(16'h8048, 1'b1, 1'b1, 16'hF00F, {$urandom, $urandom, $urandom, $urandom}, 1);
        applyStimulus(16'h8040, 1'b1, 1'b0, 16'h0000, '0, 1);
        applyStimulus(16'h0040, 1'b1, 1'b0, 16'h0000, '0, 2);

        $display("[TB] randomized traffic");
        for (int n = 0; n < 250; n++) begin
            r_addr = {9'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15))};
            r_wr   = 1'($urandom_range(0, 1));
            r_rd   = r_wr ? 1'($urandom_range(0, 1)) : 1'b1;
            r_line = {$urandom, $urandom, $urandom, $urandom};
            applyStimulus(r_addr, r_rd, r_wr, 16'($urandom), r_line, $urandom_range(1, 4));
            if ($urandom_range(0, 3) == 0) idleCycles(1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
